pcm_decoder: RTL and testbench

PCM_DECODER -- requirements
Module: pcm_decoder

---
 rtl/pcm_decoder.sv | 200 ++++++++++++++++++++
 tb/tb_pcm_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pcm_decoder.sv
// Frame synchroniser and channel demultiplexer for a serial NRZ-L PCM stream.
// Define PCM_DECODER_ERRCNT_EN to build the saturating sync-miss counter; otherwise Sync_Err_Count is 0.
module pcm_decoder #(
    parameter logic [15:0] SYNC_WORD      = 16'hEB90,
    parameter int          CHANNELS       = 128,
    parameter int          CONFIRM_FRAMES = 2,
    parameter int          MISS_LIMIT     = 3
) (
    input  logic        CLOCK_Bit,
    input  logic        Reset_N,
    input  logic        PCM,
    output logic [7:0]  Data_Word,
    output logic [6:0]  Channel_Index,
    output logic        Word_Valid,
    output logic        Frame_Start,
    output logic        Sync_Lock,
    output logic [15:0] Sync_Err_Count
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCK   = 2'd2
    } state_t;

    localparam logic [9:0] LAST_POS   = 10'(CHANNELS * 8 - 1);
    localparam logic [7:0] HIT_TARGET = 8'(CONFIRM_FRAMES + 1);
    localparam logic [7:0] MISS_MAX   = 8'(MISS_LIMIT);

    state_t      state_q, state_d;
    // Only the 15 youngest bits are ever needed; the 16th comes straight from PCM.
    logic [14:0] sh_q;
    logic [9:0]  bit_pos_q, bit_pos_d;
    logic [7:0]  hit_cnt_q, hit_cnt_d;
    logic [7:0]  miss_cnt_q, miss_cnt_d;
    logic [7:0]  data_q, data_d;
    logic [6:0]  chan_q, chan_d;
    logic        word_valid_q, word_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        sync_lock_q, sync_lock_d;

    logic [15:0] cand_s;
    logic        sync_hit_s;
    logic        at_sync_s;
    logic [9:0]  pos_inc_s;
    logic [7:0]  hit_inc_s;
    logic [7:0]  miss_inc_s;

    assign cand_s     = {sh_q, PCM};
    assign sync_hit_s = (cand_s == SYNC_WORD);
    assign at_sync_s  = (bit_pos_q == 10'd15);
    assign pos_inc_s  = (bit_pos_q == LAST_POS) ? 10'd0 : bit_pos_q + 10'd1;
    assign hit_inc_s  = hit_cnt_q + 8'd1;
    assign miss_inc_s = miss_cnt_q + 8'd1;

    // State, shift register, frame position and hit/miss counters.
    always_ff @(posedge CLOCK_Bit) begin
        if (!Reset_N) begin
            state_q    <= ST_SEARCH;
            sh_q       <= 15'd0;
            bit_pos_q  <= 10'd0;
            hit_cnt_q  <= 8'd0;
            miss_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            sh_q       <= cand_s[14:0];
            bit_pos_q  <= bit_pos_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Next-state logic: search, confirm, then flywheel through isolated misses.
    always_comb begin
        state_d    = state_q;
        bit_pos_d  = bit_pos_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            ST_SEARCH: begin
                miss_cnt_d = 8'd0;
                if (sync_hit_s) begin
                    state_d   = ST_CHECK;
                    bit_pos_d = 10'd16;
                    hit_cnt_d = 8'd1;
                end else begin
                    state_d = ST_SEARCH;
                end
            end
            ST_CHECK: begin
                bit_pos_d = pos_inc_s;
                if (at_sync_s && sync_hit_s) begin
                    hit_cnt_d = hit_inc_s;
                    if (hit_inc_s == HIT_TARGET) begin
                        state_d    = ST_LOCK;
                        miss_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else if (at_sync_s) begin
                    state_d = ST_SEARCH;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_LOCK: begin
                bit_pos_d = pos_inc_s;
                if (at_sync_s && sync_hit_s) begin
                    miss_cnt_d = 8'd0;
                end else if (at_sync_s && (miss_inc_s >= MISS_MAX)) begin
                    state_d    = ST_SEARCH;
                    miss_cnt_d = 8'd0;
                end else if (at_sync_s) begin
                    miss_cnt_d = miss_inc_s;
                end else begin
                    miss_cnt_d = miss_cnt_q;
                end
            end
            default: begin
                state_d = ST_SEARCH;
            end
        endcase
    end

    // Output logic: a channel completes on its last bit, sync channels 0-1 excluded.
    always_comb begin
        data_d        = data_q;
        chan_d        = chan_q;
        word_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        sync_lock_d   = (state_d == ST_LOCK);
        if ((state_q == ST_LOCK) && (bit_pos_q[2:0] == 3'd7) && (bit_pos_q >= 10'd23)) begin
            data_d       = cand_s[7:0];
            chan_d       = bit_pos_q[9:3];
            word_valid_d = 1'b1;
        end else begin
            word_valid_d = 1'b0;
        end
        if (at_sync_s && sync_hit_s &&
            ((state_q == ST_LOCK) || ((state_q == ST_CHECK) && (hit_inc_s == HIT_TARGET)))) begin
            frame_start_d = 1'b1;
        end else begin
            frame_start_d = 1'b0;
        end
    end

    // Registered outputs.
    always_ff @(posedge CLOCK_Bit) begin
        if (!Reset_N) begin
            data_q        <= 8'd0;
            chan_q        <= 7'd0;
            word_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            sync_lock_q   <= 1'b0;
        end else begin
            data_q        <= data_d;
            chan_q        <= chan_d;
            word_valid_q  <= word_valid_d;
            frame_start_q <= frame_start_d;
            sync_lock_q   <= sync_lock_d;
        end
    end

    assign Data_Word     = data_q;
    assign Channel_Index = chan_q;
    assign Word_Valid    = word_valid_q;
    assign Frame_Start   = frame_start_q;
    assign Sync_Lock     = sync_lock_q;

`ifdef PCM_DECODER_ERRCNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        lock_miss_s;

    assign lock_miss_s = (state_q == ST_LOCK) && at_sync_s && !sync_hit_s;

    // Saturating count of sync misses seen while locked.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (lock_miss_s && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Miss counter register, cleared only by reset.
    always_ff @(posedge CLOCK_Bit) begin
        if (!Reset_N) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign Sync_Err_Count = err_cnt_q;
`else
    assign Sync_Err_Count = 16'h0000;
`endif

endmodule

// File: tb/tb_pcm_decoder.sv
// Scoreboard bench for pcm_decoder: default 128-channel instance plus a 4-channel 1ACF instance.
module tb_pcm_decoder;

`ifdef PCM_DECODER_ERRCNT_EN
    localparam int ERR_ON = 1;
`else
    localparam int ERR_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcm_a, pcm_b;
    logic [7:0]  dw_a, dw_b;
    logic [6:0]  ci_a, ci_b;
    logic        wv_a, wv_b, fs_a, fs_b, lk_a, lk_b;
    logic [15:0] ec_a, ec_b;

    int n_cmp = 0;
    int n_err = 0;
    int fs_cnt_a = 0, fs_exp_a = 0;
    int fs_cnt_b = 0, fs_exp_b = 0;
    logic [14:0] sb_a[$];
    logic [14:0] sb_b[$];

    always #5 clk = ~clk;

    pcm_decoder dut_a (
        .CLOCK_Bit(clk), .Reset_N(rst_n), .PCM(pcm_a),
        .Data_Word(dw_a), .Channel_Index(ci_a), .Word_Valid(wv_a),
        .Frame_Start(fs_a), .Sync_Lock(lk_a), .Sync_Err_Count(ec_a)
    );

    pcm_decoder #(.SYNC_WORD(16'h1ACF), .CHANNELS(4)) dut_b (
        .CLOCK_Bit(clk), .Reset_N(rst_n), .PCM(pcm_b),
        .Data_Word(dw_b), .Channel_Index(ci_b), .Word_Valid(wv_b),
        .Frame_Start(fs_b), .Sync_Lock(lk_b), .Sync_Err_Count(ec_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Word_Valid pulses are matched in order against the expected-word queues.
    always @(negedge clk) begin : mon
        logic [14:0] exp_w;
        if (wv_a) begin
            if (sb_a.size() == 0) begin
                check_eq("a_wv_unexpected", 32'(wv_a), 32'd0);
            end else begin
                exp_w = sb_a.pop_front();
                check_eq("a_word", 32'({ci_a, dw_a}), 32'(exp_w));
            end
        end
        if (wv_b) begin
            if (sb_b.size() == 0) begin
                check_eq("b_wv_unexpected", 32'(wv_b), 32'd0);
            end else begin
                exp_w = sb_b.pop_front();
                check_eq("b_word", 32'({ci_b, dw_b}), 32'(exp_w));
            end
        end
        if (fs_a) fs_cnt_a++;
        if (fs_b) fs_cnt_b++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input int dut, input logic b);
        if (dut == 0) pcm_a = b;
        else pcm_b = b;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int dut, input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(dut, v[i]);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pcm_a = 1'b0;
        pcm_b = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_data", 32'(dw_a), 32'd0);
        check_eq("rst_chan", 32'(ci_a), 32'd0);
        check_eq("rst_wv", 32'(wv_a), 32'd0);
        check_eq("rst_fs", 32'(fs_a), 32'd0);
        check_eq("rst_lock", 32'(lk_a), 32'd0);
        check_eq("rst_errcnt", 32'(ec_a), 32'd0);
        check_eq("rst_lock_b", 32'(lk_b), 32'd0);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] chan_byte(input int c, input bit fake);
        if (fake && c == 5) return 8'hEB;
        else if (fake && c == 6) return 8'h90;
        else return 8'(c);
    endfunction

    // mode 0: no words, 1: aligned words, 2: words taken one bit early (extra bit inserted before)
    task automatic frame_a(input logic [15:0] sw, input bit fake, input int mode,
                           input logic exp_lk, input logic exp_fs, input int rst_ch);
        int m;
        logic [7:0] v, prev;
        m = mode;
        send_byte(0, sw[15:8]);
        send_byte(0, sw[7:0]);
        check_eq("a_lock_at_sync", 32'(lk_a), 32'(exp_lk));
        check_eq("a_fs_at_sync", 32'(fs_a), 32'(exp_fs));
        if (exp_fs) fs_exp_a++;
        for (int c = 2; c < 128; c++) begin
            if (c == rst_ch) begin
                do_reset();
                m = 0;
            end
            v    = chan_byte(c, fake);
            prev = (c == 2) ? sw[7:0] : chan_byte(c - 1, fake);
            if (m == 1) sb_a.push_back({7'(c), v});
            else if (m == 2) sb_a.push_back({7'(c), prev[0], v[7:1]});
            send_byte(0, v);
        end
    endtask

    function automatic logic [7:0] tbl_b(input int i);
        case (i % 4)
            0: return 8'h12;
            1: return 8'h34;
            2: return 8'h56;
            default: return 8'h6B;
        endcase
    endfunction

    task automatic frame_b(input int idx, input bit words, input logic exp_lk, input logic exp_fs);
        logic [7:0] v2, v3;
        v2 = tbl_b(idx);
        v3 = tbl_b(idx + 1);
        send_byte(1, 8'h1A);
        send_byte(1, 8'hCF);
        check_eq("b_lock_at_sync", 32'(lk_b), 32'(exp_lk));
        check_eq("b_fs_at_sync", 32'(fs_b), 32'(exp_fs));
        if (exp_fs) fs_exp_b++;
        if (words) sb_b.push_back({7'd2, v2});
        send_byte(1, v2);
        if (words) sb_b.push_back({7'd3, v3});
        send_byte(1, v3);
    endtask

    initial begin
        rst_n = 1'b0;
        pcm_a = 1'b0;
        pcm_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Small configuration: 32-bit frames, lock on the third sync.
        frame_b(0, 1'b0, 1'b0, 1'b0);
        frame_b(1, 1'b0, 1'b0, 1'b0);
        frame_b(2, 1'b1, 1'b1, 1'b1);
        for (int f = 3; f < 7; f++) frame_b(f, 1'b1, 1'b1, 1'b1);
        do_reset();

        // Fake sync inside an unsynchronised frame, then true acquisition.
        frame_a(16'h0000, 1'b1, 0, 1'b0, 1'b0, -1);
        frame_a(16'hEB90, 1'b0, 0, 1'b0, 1'b0, -1);
        frame_a(16'hEB90, 1'b0, 0, 1'b0, 1'b0, -1);
        frame_a(16'hEB90, 1'b0, 0, 1'b0, 1'b0, -1);
        frame_a(16'hEB90, 1'b0, 1, 1'b1, 1'b1, -1);
        frame_a(16'hEB90, 1'b0, 1, 1'b1, 1'b1, -1);

        // One extra bit: two flywheel frames, drop, re-acquire on the new alignment.
        send_bit(0, 1'b0);
        frame_a(16'hEB90, 1'b0, 2, 1'b1, 1'b0, -1);
        frame_a(16'hEB90, 1'b0, 2, 1'b1, 1'b0, -1);
        frame_a(16'hEB90, 1'b0, 0, 1'b0, 1'b0, -1);
        frame_a(16'hEB90, 1'b0, 0, 1'b0, 1'b0, -1);
        frame_a(16'hEB90, 1'b0, 1, 1'b1, 1'b1, -1);
        check_eq("a_errcnt_slip", 32'(ec_a), (ERR_ON != 0) ? 32'd3 : 32'd0);

        // Two corrupted syncs twice; the hit in between must clear the miss count.
        frame_a(16'h0000, 1'b0, 1, 1'b1, 1'b0, -1);
        frame_a(16'h0000, 1'b0, 1, 1'b1, 1'b0, -1);
        frame_a(16'hEB90, 1'b0, 1, 1'b1, 1'b1, -1);
        frame_a(16'h0000, 1'b0, 1, 1'b1, 1'b0, -1);
        frame_a(16'h0000, 1'b0, 1, 1'b1, 1'b0, -1);
        frame_a(16'hEB90, 1'b0, 1, 1'b1, 1'b1, -1);
        check_eq("a_errcnt_flywheel", 32'(ec_a), (ERR_ON != 0) ? 32'd7 : 32'd0);

        // Reset pulse mid-frame while locked, then full re-acquisition.
        frame_a(16'hEB90, 1'b0, 1, 1'b1, 1'b1, 60);
        frame_a(16'hEB90, 1'b0, 0, 1'b0, 1'b0, -1);
        frame_a(16'hEB90, 1'b0, 0, 1'b0, 1'b0, -1);
        frame_a(16'hEB90, 1'b0, 1, 1'b1, 1'b1, -1);

        repeat (3) @(posedge clk);
        #1;
        check_eq("a_sb_left", 32'(sb_a.size()), 32'd0);
        check_eq("b_sb_left", 32'(sb_b.size()), 32'd0);
        check_eq("a_fs_total", 32'(fs_cnt_a), 32'(fs_exp_a));
        check_eq("b_fs_total", 32'(fs_cnt_b), 32'(fs_exp_b));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
